// File: rtl/autocorr_engine.sv
//==============================================================================
// autocorr_engine
// Buffers one Q1.15 frame and computes lags R0..R10 with a single pipelined MAC.
// Rev 1.0
//==============================================================================
`default_nettype none

module autocorr_engine #(
    parameter int FRAME_LEN  = 256,
    parameter int LOG2_FRAME = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               r_valid,
    input  logic               r_ack,
    output logic signed [15:0] R0,
    output logic signed [15:0] R1,
    output logic signed [15:0] R2,
    output logic signed [15:0] R3,
    output logic signed [15:0] R4,
    output logic signed [15:0] R5,
    output logic signed [15:0] R6,
    output logic signed [15:0] R7,
    output logic signed [15:0] R8,
    output logic signed [15:0] R9,
    output logic signed [15:0] R10
);

    localparam int NUM_LAGS = 11;
    localparam int ACC_W    = 33 + LOG2_FRAME;
    localparam int SHIFT    = 15 + LOG2_FRAME;
    localparam logic [3:0]            LAST_LAG = 4'd10;
    localparam logic [LOG2_FRAME-1:0] LAST_IDX = LOG2_FRAME'(FRAME_LEN - 1);

    typedef enum logic [1:0] {FILL, COMPUTE, HOLD} state_t;
    typedef enum logic [1:0] {ISSUE, DRAIN, WB} phase_t;

    state_t state, state_next;
    phase_t phase, phase_next;

    logic [LOG2_FRAME-1:0]     wr_ptr;
    logic [LOG2_FRAME-1:0]     n_idx;
    logic [3:0]                lag;
    logic signed [31:0]        prod;
    logic                      prod_vld;
    logic signed [ACC_W-1:0]   acc;
    logic signed [15:0]        r_reg [NUM_LAGS];
    logic signed [15:0]        sample_mem [FRAME_LEN];

    logic [LOG2_FRAME-1:0]     lag_ext;
    logic [LOG2_FRAME-1:0]     rd_b_idx;
    logic signed [15:0]        op_a;
    logic signed [15:0]        op_b;
    logic signed [31:0]        mult;
    logic signed [ACC_W-1:0]   shifted;
    logic                      sat_hi;
    logic                      sat_lo;
    logic signed [15:0]        sat_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            phase <= ISSUE;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        s_ready    = 1'b0;
        r_valid    = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && (wr_ptr == LAST_IDX)) begin
                    state_next = COMPUTE;
                    phase_next = ISSUE;
                end
            end
            COMPUTE: begin
                case (phase)
                    ISSUE:   if (n_idx == LAST_IDX) phase_next = DRAIN;
                    DRAIN:   phase_next = WB;
                    WB: begin
                        phase_next = ISSUE;
                        if (lag == LAST_LAG) state_next = HOLD;
                    end
                    default: phase_next = ISSUE;
                endcase
            end
            HOLD: begin
                r_valid = 1'b1;
                if (r_ack) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Two combinational reads per cycle: buf[n] and buf[n-k]
    assign lag_ext  = {{(LOG2_FRAME-4){1'b0}}, lag};
    assign rd_b_idx = n_idx - lag_ext;
    assign op_a     = sample_mem[n_idx];
    assign op_b     = sample_mem[rd_b_idx];
    assign mult     = op_a * op_b;

    // Floor shift then clamp to the Q1.15 range
    assign shifted = acc >>> SHIFT;
    assign sat_hi  = !shifted[ACC_W-1] && (|shifted[ACC_W-2:15]);
    assign sat_lo  = shifted[ACC_W-1] && !(&shifted[ACC_W-2:15]);
    assign sat_val = sat_hi ? 16'sh7FFF :
                     sat_lo ? 16'sh8000 : shifted[15:0];

    always_ff @(posedge clk) begin
        if (state == FILL && s_valid) sample_mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            n_idx    <= '0;
            lag      <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            for (int i = 0; i < NUM_LAGS; i++) r_reg[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    n_idx    <= '0;
                    lag      <= '0;
                    prod_vld <= 1'b0;
                    if (s_valid) wr_ptr <= wr_ptr + 1'b1;
                end
                COMPUTE: begin
                    prod_vld <= (phase == ISSUE);
                    if (phase == ISSUE) begin
                        prod  <= mult;
                        n_idx <= n_idx + 1'b1;
                    end
                    if (prod_vld) acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
                    if (phase == WB) begin
                        r_reg[lag] <= sat_val;
                        acc        <= '0;
                        lag        <= lag + 4'd1;
                        n_idx      <= lag_ext + 1'b1;
                    end
                end
                default: prod_vld <= 1'b0;
            endcase
        end
    end

    assign R0  = r_reg[0];
    assign R1  = r_reg[1];
    assign R2  = r_reg[2];
    assign R3  = r_reg[3];
    assign R4  = r_reg[4];
    assign R5  = r_reg[5];
    assign R6  = r_reg[6];
    assign R7  = r_reg[7];
    assign R8  = r_reg[8];
    assign R9  = r_reg[9];
    assign R10 = r_reg[10];

endmodule

`default_nettype wire

// File: tb/tb_autocorr_engine.sv
//==============================================================================
// tb_autocorr_engine
// Directed frame vectors with hand-derived lag results plus reset sequences.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_autocorr_engine;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic               r_valid;
    logic               r_ack = 1'b0;
    logic signed [15:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10;
    logic signed [15:0] r_out [11];

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0]        a;       // even-index sample
        logic [15:0]        b;       // odd-index sample
        bit                 gaps;    // random s_valid drops during fill
        bit                 hold;    // keep s_valid high after the frame
        int                 ack_mode;// 0 normal, 1 ack during compute, 2 ack held
        logic [10:0][15:0]  exp_r;
    } vec_t;

    vec_t vecs[5];

    autocorr_engine #(.FRAME_LEN(256), .LOG2_FRAME(8)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .r_valid(r_valid), .r_ack(r_ack),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5),
        .R6(R6), .R7(R7), .R8(R8), .R9(R9), .R10(R10)
    );

    assign r_out[0] = R0;  assign r_out[1] = R1;  assign r_out[2]  = R2;
    assign r_out[3] = R3;  assign r_out[4] = R4;  assign r_out[5]  = R5;
    assign r_out[6] = R6;  assign r_out[7] = R7;  assign r_out[8]  = R8;
    assign r_out[9] = R9;  assign r_out[10] = R10;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic any_r;
        any_r = 1'b0;
        for (int k = 0; k < 11; k++) if (r_out[k] !== 16'sd0) any_r = 1'b1;
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_r_valid"}, 32'(r_valid), 32'd0);
        check({tag, "_r_nonzero"}, 32'(any_r), 32'd0);
    endtask

    task automatic fill_frame(input logic [15:0] a, input logic [15:0] b,
                              input bit gaps, input bit hold);
        int taken;
        int guard;
        taken = 0;
        guard = 0;
        while (taken < 256 && guard < 5000) begin
            @(negedge clk);
            if (gaps && $urandom_range(3) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = (taken % 2 == 0) ? a : b;
            end
            if (s_valid && s_ready) taken++;
            guard++;
        end
        if (taken < 256) begin
            $display("FAIL fill_timeout: got %0d samples expected 256", taken);
            n_fail++;
            n_cmp++;
        end
        @(posedge clk);
        #1;
        if (hold) s_data = 16'sh7FFF;
        else      s_valid = 1'b0;
    endtask

    // Counts edges after the one taking the last sample until r_valid shows.
    task automatic wait_result(input int ack_mode);
        int cnt;
        int bad_ready;
        cnt = 0;
        bad_ready = 0;
        @(negedge clk);
        while (!r_valid && cnt < 4000) begin
            if (s_ready) bad_ready++;
            r_ack = (ack_mode == 2) || (ack_mode == 1 && cnt >= 100 && cnt < 200);
            @(negedge clk);
            cnt++;
        end
        // accepting edge plus cnt further edges
        check("latency_edges", cnt + 1, 2784);
        check("s_ready_in_compute", bad_ready, 0);
    endtask

    task automatic check_results(input int vi);
        for (int k = 0; k < 11; k++)
            check($sformatf("v%0d_R%0d", vi, k), r_out[k], $signed(vecs[vi].exp_r[k]));
    endtask

    task automatic release_result(input int ack_mode);
        if (ack_mode == 2) begin
            @(negedge clk);
            check("hold_one_cycle_r_valid", 32'(r_valid), 32'd0);
            check("hold_one_cycle_s_ready", 32'(s_ready), 32'd1);
            r_ack   = 1'b0;
            s_valid = 1'b0;
        end else begin
            @(negedge clk);
            check("hold_stable_r_valid", 32'(r_valid), 32'd1);
            check("hold_stable_s_ready", 32'(s_ready), 32'd0);
            r_ack   = 1'b1;
            s_valid = 1'b0;
            @(negedge clk);
            r_ack = 1'b0;
            check("ack_r_valid", 32'(r_valid), 32'd0);
            check("ack_s_ready", 32'(s_ready), 32'd1);
        end
    endtask

    task automatic run_vec(input int vi);
        fill_frame(vecs[vi].a, vecs[vi].b, vecs[vi].gaps, vecs[vi].hold);
        wait_result(vecs[vi].ack_mode);
        check_results(vi);
        release_result(vecs[vi].ack_mode);
    endtask

    initial begin
        for (int k = 0; k < 11; k++) begin
            int dc;
            dc = (256 - k) * 32;
            vecs[0].exp_r[k] = 16'(dc);
            vecs[1].exp_r[k] = 16'((k % 2) ? -dc : dc);
            vecs[2].exp_r[k] = 16'((k == 0) ? 32767 : (256 - k) * 128);
            vecs[3].exp_r[k] = 16'(dc);
            vecs[4].exp_r[k] = 16'((k % 2) ? -1 : 0);   // floor of tiny negatives
        end
        vecs[0].a = 16'h4000; vecs[0].b = 16'h4000; vecs[0].gaps = 0; vecs[0].hold = 0; vecs[0].ack_mode = 0;
        vecs[1].a = 16'h4000; vecs[1].b = 16'hC000; vecs[1].gaps = 0; vecs[1].hold = 0; vecs[1].ack_mode = 0;
        vecs[2].a = 16'h8000; vecs[2].b = 16'h8000; vecs[2].gaps = 0; vecs[2].hold = 0; vecs[2].ack_mode = 0;
        vecs[3].a = 16'h4000; vecs[3].b = 16'h4000; vecs[3].gaps = 1; vecs[3].hold = 1; vecs[3].ack_mode = 1;
        vecs[4].a = 16'h0001; vecs[4].b = 16'hFFFF; vecs[4].gaps = 0; vecs[4].hold = 0; vecs[4].ack_mode = 2;

        // Asynchronous reset asserted between edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_release");

        for (int vi = 0; vi < 5; vi++) run_vec(vi);

        // Reset 1000 cycles into COMPUTE, after early lags were written
        fill_frame(16'h4000, 16'h4000, 1'b0, 1'b0);
        repeat (1000) @(negedge clk);
        check("pre_reset_R0", R0, 32'sd8192);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_compute_reset");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_compute_release");
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
